// File: rtl/lag_measure_ctrl_if.sv
// Control/status bundle between the UI logic, the BCD tick counter and the
// photo-sensor front end on one side and lag_measure_ctrl on the other.
interface lag_measure_ctrl_if;
    logic        start;
    logic        abort;
    logic        sensor;
    logic [23:0] cnt_value;
    logic        flash;
    logic        cnt_clear;
    logic        cnt_tick;
    logic [23:0] last_lag;
    logic [23:0] min_lag;
    logic [23:0] max_lag;
    logic [7:0]  run_index;
    logic        busy;
    logic        done;
    logic        timeout;

    modport master (
        output start, abort, sensor, cnt_value,
        input  flash, cnt_clear, cnt_tick, last_lag, min_lag, max_lag,
               run_index, busy, done, timeout
    );

    modport slave (
        input  start, abort, sensor, cnt_value,
        output flash, cnt_clear, cnt_tick, last_lag, min_lag, max_lag,
               run_index, busy, done, timeout
    );
endinterface

// File: rtl/lag_measure_ctrl.sv
// Display-lag measurement sequencer: IDLE -> CLEAR -> (DARK -> MEASURE -> CAP1 -> CAP2 -> GAP) x RUNS.
// Drives flash/counter control, captures BCD lag per run and tracks last/min/max.
module lag_measure_ctrl #(
    parameter int TICK_DIV      = 100,
    parameter int SETTLE_CYCLES = 1000,
    parameter int TIMEOUT_TICKS = 50000,
    parameter int RUNS          = 16
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    lag_measure_ctrl_if.slave  bus
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int PW = $clog2(TICK_DIV);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TICKS_MAX   = TW'(TIMEOUT_TICKS);
    localparam logic [7:0]    RUNS_N      = 8'(RUNS);
    localparam logic [23:0]   BCD_MAX     = 24'h999999;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_DARK, S_MEASURE, S_CAP1, S_CAP2, S_GAP
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [SW-1:0] r_settle;
    logic [PW-1:0] r_presc;
    logic [TW-1:0] r_ticks;
    logic          r_flash, r_clear, r_tick, r_busy, r_done, r_timeout;
    logic [23:0]   r_last, r_min, r_max;
    logic [7:0]    r_run;
    logic          w_abort, w_timeout_hit, w_series_done, w_tick, w_measuring, w_lit;

    always_comb begin
        w_next        = r_state;
        w_timeout_hit = 1'b0;
        w_series_done = 1'b0;
        case (r_state)
            S_IDLE:    if (bus.start) w_next = S_CLEAR;
            S_CLEAR:   w_next = S_DARK;
            S_DARK:    if (!bus.sensor && r_settle == SETTLE_LAST) w_next = S_MEASURE;
            S_MEASURE: begin
                // Light detection takes precedence over a simultaneous timeout.
                if (bus.sensor) begin
                    w_next = S_CAP1;
                end else if (r_ticks == TICKS_MAX) begin
                    w_next        = S_IDLE;
                    w_timeout_hit = 1'b1;
                end
            end
            S_CAP1:    w_next = S_CAP2;
            S_CAP2:    w_next = S_GAP;
            S_GAP: begin
                if (r_run == RUNS_N) begin
                    w_next        = S_IDLE;
                    w_series_done = 1'b1;
                end else begin
                    w_next = S_DARK;
                end
            end
            default:   w_next = S_IDLE;
        endcase
        w_abort = bus.abort && (r_state != S_IDLE);
        if (w_abort) begin
            w_next        = S_IDLE;
            w_timeout_hit = 1'b0;
            w_series_done = 1'b0;
        end
        w_measuring = (r_state == S_MEASURE) && (w_next == S_MEASURE);
        w_tick      = w_measuring && (r_presc == PRESC_LAST);
        w_lit       = (w_next == S_MEASURE) || (w_next == S_CAP1) || (w_next == S_CAP2);
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state   <= S_IDLE;
            r_settle  <= '0;
            r_presc   <= '0;
            r_ticks   <= '0;
            r_flash   <= 1'b0;
            r_clear   <= 1'b1;
            r_tick    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_last    <= '0;
            r_min     <= BCD_MAX;
            r_max     <= '0;
            r_run     <= '0;
        end else begin
            r_state <= w_next;
            r_flash <= w_lit;
            r_clear <= !w_lit;
            r_busy  <= (w_next != S_IDLE);
            r_done  <= w_series_done;
            r_tick  <= w_tick;

            // Settle counter only survives consecutive dark cycles spent in DARK.
            r_settle <= (r_state == S_DARK && !bus.sensor && w_next == S_DARK)
                        ? r_settle + 1'b1 : '0;
            r_presc  <= !w_measuring ? '0 : (r_presc == PRESC_LAST) ? '0 : r_presc + 1'b1;
            r_ticks  <= w_measuring ? r_ticks + TW'(w_tick) : '0;

            if (r_state == S_CLEAR && !w_abort) begin
                r_min     <= BCD_MAX;
                r_max     <= '0;
                r_run     <= '0;
                r_timeout <= 1'b0;
            end
            if (w_timeout_hit) r_timeout <= 1'b1;

            // Packed BCD orders the same as its unsigned binary encoding.
            if (r_state == S_CAP2 && !w_abort) begin
                r_last <= bus.cnt_value;
                if (bus.cnt_value < r_min) r_min <= bus.cnt_value;
                if (bus.cnt_value > r_max) r_max <= bus.cnt_value;
                r_run <= r_run + 8'd1;
            end
        end
    end

    assign bus.flash     = r_flash;
    assign bus.cnt_clear = r_clear;
    assign bus.cnt_tick  = r_tick;
    assign bus.last_lag  = r_last;
    assign bus.min_lag   = r_min;
    assign bus.max_lag   = r_max;
    assign bus.run_index = r_run;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.timeout   = r_timeout;
endmodule

// File: tb/tb_lag_measure_ctrl.sv
// Bench for lag_measure_ctrl with a behavioural BCD tick counter; expected lag per
// run is floor(sensor delay / TICK_DIV), min/max tracked with plain integers.
module tb_lag_measure_ctrl;
    localparam int TDIV    = 4;
    localparam int SETTLE  = 8;
    localparam int TMO     = 20;
    localparam int NRUNS   = 3;

    logic clk;
    logic reset_n;
    int   n_cmp = 0;
    int   n_err = 0;
    int   tick_seen = 0;
    int   done_seen = 0;
    int   cnt_bin = 0;
    int   m_last = 0;
    int   m_min = 0;
    int   m_max = 0;

    lag_measure_ctrl_if bus ();

    lag_measure_ctrl #(
        .TICK_DIV(TDIV), .SETTLE_CYCLES(SETTLE), .TIMEOUT_TICKS(TMO), .RUNS(NRUNS)
    ) dut (
        .i_clock  (clk),
        .i_reset_n(reset_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int          d;
        r = '0;
        d = v;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(d % 10);
            d = d / 10;
        end
        return r;
    endfunction

    // Behavioural 6-digit decimal counter outside the DUT.
    always @(posedge clk) begin
        if (bus.cnt_clear) cnt_bin <= 0;
        else if (bus.cnt_tick) cnt_bin <= (cnt_bin + 1) % 1000000;
    end
    assign bus.cnt_value = to_bcd(cnt_bin);

    always @(negedge clk) begin
        if (bus.cnt_tick === 1'b1) tick_seen <= tick_seen + 1;
        if (bus.done === 1'b1) done_seen <= done_seen + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
    endtask

    task automatic wait_flash(input string tag);
        int w;
        w = 0;
        while (bus.flash !== 1'b1 && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk(tag, 32'(w < 300), 32'd1);
    endtask

    // One measurement: sensor lights n cycles after flash first observed.
    task automatic do_run(input int n);
        int w;
        int exp_t;
        exp_t = n / TDIV;
        tick_seen = 0;
        wait_flash("flash_rise");
        repeat (n) @(posedge clk);
        #1 bus.sensor = 1'b1;
        w = 0;
        @(negedge clk);
        while (bus.flash !== 1'b0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        bus.sensor = 1'b0;
        m_last = exp_t;
        if (exp_t < m_min) m_min = exp_t;
        if (exp_t > m_max) m_max = exp_t;
        chk("run_ticks", 32'(tick_seen), 32'(exp_t));
        chk("last_lag", 32'(bus.last_lag), 32'(to_bcd(m_last)));
    endtask

    task automatic wait_idle(input string tag);
        int w;
        w = 0;
        @(negedge clk);
        while (bus.busy === 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk(tag, 32'(w < 400), 32'd1);
    endtask

    task automatic run_series(input int n0, input int n1, input int n2);
        int d0;
        d0 = done_seen;
        m_min = 1000000;
        m_max = 0;
        pulse_start();
        do_run(n0);
        do_run(n1);
        do_run(n2);
        wait_idle("series_end");
        repeat (3) @(negedge clk);
        chk("series_min", 32'(bus.min_lag), 32'(to_bcd(m_min)));
        chk("series_max", 32'(bus.max_lag), 32'(to_bcd(m_max)));
        chk("series_runs", 32'(bus.run_index), 32'(NRUNS));
        chk("series_done", 32'(done_seen), 32'(d0 + 1));
        chk("series_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int w;
        int d0;
        logic saw_flash;

        reset_n    = 1'b0;
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus.sensor = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_flash", 32'(bus.flash), 32'd0);
        chk("rst_clear", 32'(bus.cnt_clear), 32'd1);
        chk("rst_tick", 32'(bus.cnt_tick), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_timeout", 32'(bus.timeout), 32'd0);
        chk("rst_last", 32'(bus.last_lag), 32'd0);
        chk("rst_min", 32'(bus.min_lag), 32'h999999);
        chk("rst_max", 32'(bus.max_lag), 32'd0);
        chk("rst_runs", 32'(bus.run_index), 32'd0);
        reset_n = 1'b1;

        // Directed series: delays 10/30/18 -> 2/7/4 ticks.
        run_series(10, 30, 18);

        // Sensor never lights: timeout after TMO ticks, no done.
        d0 = done_seen;
        pulse_start();
        tick_seen = 0;
        wait_idle("timeout_end");
        chk("timeout_ticks", 32'(tick_seen), 32'(TMO));
        chk("timeout_flag", 32'(bus.timeout), 32'd1);
        chk("timeout_flash", 32'(bus.flash), 32'd0);
        repeat (2) @(negedge clk);
        chk("timeout_no_done", 32'(done_seen), 32'(d0));

        // Restart clears timeout; sensor toggles in DARK every 5 cycles.
        m_min = 1000000;
        m_max = 0;
        pulse_start();
        saw_flash = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bus.sensor = 1'((i / 5) % 2);
            @(negedge clk);
            if (bus.flash === 1'b1) saw_flash = 1'b1;
            @(posedge clk); #1;
        end
        chk("toggle_no_flash", 32'(saw_flash), 32'd0);
        chk("restart_timeout", 32'(bus.timeout), 32'd0);
        bus.sensor = 1'b0;
        w = 0;
        @(negedge clk);
        while (bus.flash !== 1'b1 && w < 30) begin
            @(negedge clk);
            w++;
        end
        chk("settle_latency", 32'(w), 32'(SETTLE));
        do_run(13);

        // Abort in the first CAPTURE cycle: nothing captured, no done.
        d0 = done_seen;
        wait_flash("abort_flash");
        repeat (9) @(posedge clk);
        #1 bus.sensor = 1'b1;
        @(posedge clk); #1 bus.abort = 1'b1;
        @(posedge clk); #1 bus.abort = 1'b0;
        bus.sensor = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_flash_off", 32'(bus.flash), 32'd0);
        chk("abort_clear", 32'(bus.cnt_clear), 32'd1);
        chk("abort_last", 32'(bus.last_lag), 32'(to_bcd(m_last)));
        chk("abort_runs", 32'(bus.run_index), 32'd1);
        repeat (5) @(negedge clk);
        chk("abort_no_done", 32'(done_seen), 32'(d0));

        // Randomised series.
        for (int s = 0; s < 3; s++) begin
            run_series(int'($urandom_range(1, 79)), int'($urandom_range(1, 79)),
                       int'($urandom_range(1, 79)));
        end

        // Reset during MEASURE of the second run.
        m_min = 1000000;
        m_max = 0;
        pulse_start();
        do_run(int'($urandom_range(4, 60)));
        wait_flash("rst_mid_flash");
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        chk("midrst_flash", 32'(bus.flash), 32'd0);
        chk("midrst_clear", 32'(bus.cnt_clear), 32'd1);
        chk("midrst_min", 32'(bus.min_lag), 32'h999999);
        chk("midrst_max", 32'(bus.max_lag), 32'd0);
        chk("midrst_runs", 32'(bus.run_index), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_timeout", 32'(bus.timeout), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
